// File: rtl/msg_padder_if.sv
// rtl/msg_padder_if.sv - message/word handshake bundle for msg_padder
//
// Purpose: groups the message-input and padded-word-output signals of
// msg_padder. The master modport is the side that supplies messages and
// consumes words. The slave modport is the padder itself.
// Signals:
//   start, msg_length, byte_valid, byte_in  message request and byte stream into the padder
//   w_ready                                 downstream accept for padded words
//   w_valid, w_data, w_index                padded block word out
//   block_done, busy                        block status out
//   len_error                               oversize-length pulse (MSG_PADDER_LEN_CHECK_EN only)
// Optional feature macro: MSG_PADDER_LEN_CHECK_EN
interface msg_padder_if #(
    parameter int LEN_W = 7
);
    logic             start;
    logic [LEN_W-1:0] msg_length;
    logic             byte_valid;
    logic [7:0]       byte_in;
    logic             w_ready;
    logic             w_valid;
    logic [31:0]      w_data;
    logic [3:0]       w_index;
    logic             block_done;
    logic             busy;
`ifdef MSG_PADDER_LEN_CHECK_EN
    logic             len_error;

    modport master (
        output start, msg_length, byte_valid, byte_in, w_ready,
        input  w_valid, w_data, w_index, block_done, busy, len_error
    );
    modport slave (
        input  start, msg_length, byte_valid, byte_in, w_ready,
        output w_valid, w_data, w_index, block_done, busy, len_error
    );
`else
    modport master (
        output start, msg_length, byte_valid, byte_in, w_ready,
        input  w_valid, w_data, w_index, block_done, busy
    );
    modport slave (
        input  start, msg_length, byte_valid, byte_in, w_ready,
        output w_valid, w_data, w_index, block_done, busy
    );
`endif
endinterface

// File: rtl/msg_padder.sv
// rtl/msg_padder.sv - single-block SHA-style message padder
//
// Purpose: collects up to MAX_MESSAGE_LENGTH bytes and then emits one padded
// 512-bit block as 16 big-endian 32-bit words. The 0x80 marker follows the
// message, zero fill comes next, and the 64-bit bit length goes in words 14..15.
// Ports:
//   clock_i   single rising-edge clock
//   reset_ni  asynchronous active-low reset
//   bus       msg_padder_if.slave (message in, padded words out, status)
// Optional feature macro: MSG_PADDER_LEN_CHECK_EN. When it is defined,
// oversize lengths are rejected with a len_error pulse. Otherwise they are
// saturated to MAX_MESSAGE_LENGTH.
module msg_padder #(
    parameter int MAX_MESSAGE_LENGTH = 55,
    parameter int LEN_W              = $clog2(MAX_MESSAGE_LENGTH) + 1
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    msg_padder_if.slave   bus
);
    localparam int               BUF_AW  = (MAX_MESSAGE_LENGTH > 1) ? $clog2(MAX_MESSAGE_LENGTH) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_MESSAGE_LENGTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EMIT
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic             buf_we;
    logic [7:0]       buf_q [MAX_MESSAGE_LENGTH];
    logic [31:0]      word;
    logic [5:0]       bi;
`ifdef MSG_PADDER_LEN_CHECK_EN
    logic             len_err_q, len_err_d;
`endif

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
`ifdef MSG_PADDER_LEN_CHECK_EN
            len_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
`ifdef MSG_PADDER_LEN_CHECK_EN
            len_err_q <= len_err_d;
`endif
        end
    end

    // The message buffer needs no reset. Bytes are only read below len_q,
    // and every one of them is written again after each start.
    always_ff @(posedge clock_i) begin
        if (buf_we) begin
            buf_q[cnt_q[BUF_AW-1:0]] <= bus.byte_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        buf_we    = 1'b0;
`ifdef MSG_PADDER_LEN_CHECK_EN
        len_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
`ifdef MSG_PADDER_LEN_CHECK_EN
                    if (bus.msg_length > MAX_LEN) begin
                        len_err_d = 1'b1;
                    end else begin
                        state_d = S_COLLECT;
                        len_d   = bus.msg_length;
                        cnt_d   = '0;
                    end
`else
                    state_d = S_COLLECT;
                    len_d   = (bus.msg_length > MAX_LEN) ? MAX_LEN : bus.msg_length;
                    cnt_d   = '0;
`endif
                end
            end
            S_COLLECT: begin
                // An empty message arrives here already complete.
                // Otherwise the block leaves on the edge that stores the last byte.
                if (cnt_q == len_q) begin
                    state_d = S_EMIT;
                end else if (bus.byte_valid) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_d == len_q) begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (bus.w_ready) begin
                    // The index wraps from 15 back to 0, ready for the next block.
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Build the current word from the buffer. The buffer is stable in EMIT,
    // so the word holds while the downstream stalls.
    always_comb begin
        word = '0;
        bi   = '0;
        if (idx_q == 4'd15) begin
            word = 32'(len_q) << 3;
        end else if (idx_q != 4'd14) begin
            for (int k = 0; k < 4; k++) begin
                bi = {idx_q, 2'(k)};
                if (32'(bi) < 32'(len_q)) begin
                    word[31-8*k -: 8] = buf_q[bi[BUF_AW-1:0]];
                end else if (32'(bi) == 32'(len_q)) begin
                    word[31-8*k -: 8] = 8'h80;
                end
            end
        end
    end

    assign bus.w_valid    = (state_q == S_EMIT);
    assign bus.w_data     = (state_q == S_EMIT) ? word : 32'd0;
    assign bus.w_index    = idx_q;
    assign bus.block_done = done_q;
    assign bus.busy       = (state_q != S_IDLE);
`ifdef MSG_PADDER_LEN_CHECK_EN
    assign bus.len_error  = len_err_q;
`endif

endmodule

// File: tb/tb_msg_padder.sv
// tb/tb_msg_padder.sv - scoreboard testbench for msg_padder
module tb_msg_padder;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    msg_padder_if #(.LEN_W(7)) bus ();

    msg_padder #(.MAX_MESSAGE_LENGTH(55), .LEN_W(7)) dut (
        .clock_i  (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   xfer_cnt = 0;
    int   vcyc     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every word transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.w_valid) vcyc++;
            if (bus.block_done) begin
                done_cnt++;
                chk("done_wvalid_low", 32'(bus.w_valid), 32'd0);
            end
            if (bus.w_valid && bus.w_ready) begin
                xfer_cnt++;
                if (sb.size() == 0) begin
                    chk("sb_word_expected", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("w_index[%0d]", e.idx), 32'(bus.w_index), 32'(e.idx));
                    chk($sformatf("w_data[%0d]", e.idx), bus.w_data, e.data);
                end
            end
        end
    end

    task automatic push_block(input int len, input logic [7:0] base);
        logic [7:0] m [56];
        for (int i = 0; i < 56; i++) begin
            if (i < len)       m[i] = base + 8'(i);
            else if (i == len) m[i] = 8'h80;
            else               m[i] = 8'h00;
        end
        for (int w = 0; w < 14; w++)
            sb.push_back({4'(w), m[4*w], m[4*w+1], m[4*w+2], m[4*w+3]});
        sb.push_back({4'd14, 32'd0});
        sb.push_back({4'd15, 32'(len * 8)});
    endtask

    task automatic send_msg(input int len, input logic [7:0] base, input int stall_idx, input bit glitch);
        int          eff, d0, x0, v0, bound;
        bit          stalled;
        logic [31:0] hd;
        eff = (len > 55) ? 55 : len;
        push_block(eff, base);
        d0 = done_cnt; x0 = xfer_cnt; v0 = vcyc;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.msg_length = 7'(len);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        if (eff == 0) begin
            chk("len0_wvalid_early", 32'(bus.w_valid), 32'd0);
            @(posedge clk); #1;
            chk("len0_wvalid", 32'(bus.w_valid), 32'd1);
        end
        for (int j = 0; j < eff; j++) begin
            bus.byte_valid = 1'b1;
            bus.byte_in    = base + 8'(j);
            if (glitch && j == 1) begin
                bus.start = 1'b1; bus.msg_length = 7'd9;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.byte_valid = 1'b0;
        if (eff > 0) chk("wvalid_after_last_byte", 32'(bus.w_valid), 32'd1);
        stalled = 1'b0;
        for (bound = 0; bound < 100 && done_cnt == d0; bound++) begin
            if (!stalled && stall_idx >= 0 && bus.w_valid && bus.w_index == 4'(stall_idx)) begin
                hd = bus.w_data;
                bus.w_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("stall_index", 32'(bus.w_index), 32'(stall_idx));
                    chk("stall_data", bus.w_data, hd);
                    chk("stall_wvalid", 32'(bus.w_valid), 32'd1);
                end
                bus.w_ready = 1'b1;
                stalled = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("block_done_seen", 32'(done_cnt - d0), 32'd1);
        @(posedge clk); #1;
        chk("block_done_once", 32'(done_cnt - d0), 32'd1);
        chk("transfers", 32'(xfer_cnt - x0), 32'd16);
        chk("valid_cycles", 32'(vcyc - v0), (stall_idx >= 0) ? 32'd19 : 32'd16);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("idle_after_block", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_w_valid"}, 32'(bus.w_valid), 32'd0);
        chk({tag, "_w_data"}, bus.w_data, 32'd0);
        chk({tag, "_w_index"}, 32'(bus.w_index), 32'd0);
        chk({tag, "_block_done"}, 32'(bus.block_done), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.msg_length = '0; bus.byte_valid = 1'b0;
        bus.byte_in = '0; bus.w_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Bytes are ignored while the padder is idle.
        bus.byte_valid = 1'b1; bus.byte_in = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        chk("idle_ignores_bytes", 32'(bus.busy), 32'd0);

        send_msg(3, 8'h61, -1, 1'b0);
        send_msg(0, 8'h00, -1, 1'b0);
        send_msg(55, 8'h00, -1, 1'b0);
        send_msg(3, 8'h61, 5, 1'b0);
        send_msg(10, 8'hA0, -1, 1'b1);

        // Reset part-way through collecting a 10-byte message.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.msg_length = 7'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            bus.byte_valid = 1'b1; bus.byte_in = 8'(j + 1);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_collect");
        bus.byte_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset while a word is being presented with the downstream stalled.
        bus.w_ready = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.msg_length = 7'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            bus.byte_valid = 1'b1; bus.byte_in = 8'h11;
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
        chk("emit_before_rst", 32'(bus.w_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_emit");
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.w_ready = 1'b1;
        @(posedge clk); #1;
        chk("no_partial_after_rst", 32'(bus.w_valid), 32'd0);

        send_msg(3, 8'h41, -1, 1'b0);

`ifdef MSG_PADDER_LEN_CHECK_EN
        @(posedge clk); #1;
        bus.start = 1'b1; bus.msg_length = 7'd56;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("len_error_pulse", 32'(bus.len_error), 32'd1);
        chk("len_error_busy", 32'(bus.busy), 32'd0);
        chk("len_error_wvalid", 32'(bus.w_valid), 32'd0);
        @(posedge clk); #1;
        chk("len_error_clear", 32'(bus.len_error), 32'd0);
        chk("len_error_still_idle", 32'(bus.busy), 32'd0);
`else
        send_msg(60, 8'h20, -1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
